imem_dmem_port_arbiter: RTL and testbench

- Shares one single-ported, fixed-latency memory between two requesters: instruction fetch (FD stage) and data load/store (X/MW stage).
- Data requests have priority. A bounded-streak counter keeps fetch from starving.
- Tracks in-flight reads and routes each read response back to the requester that issued it.
- A flush input squashes in-flight fetch responses on a taken branch or jump; data responses are never squashed.

---
 rtl/arb_pkg.sv | 36 +++
 rtl/arb_tag_pipe.sv | 80 ++++++++
 rtl/imem_dmem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_imem_dmem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types for the imem/dmem port arbiter: arbitration states,
// requester owner codes and the tag-pipeline entry format.
package arb_pkg;

    // Arbitration state: data has priority, or fetch is owed a grant.
    typedef enum logic {
        ARB_D = 1'b0,
        ARB_I = 1'b1
    } arb_state_e;

    // Which requester issued an in-flight read.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Width of the data-streak counter; holds up to 15.
    localparam int STREAK_W = 4;

    // One in-flight access as it travels alongside the memory latency.
    typedef struct packed {
        logic valid;   // a read whose data will return
        logic owner;   // OWN_I or OWN_D
        logic squash;  // fetch read killed by a flush; data is dropped
    } tag_entry_t;

    // Move an entry one stage down the pipe, marking live fetch reads
    // as squashed when a flush is seen on the way.
    function automatic tag_entry_t age_entry(input tag_entry_t e, input logic flush);
        tag_entry_t r;
        r = e;
        if (flush && e.valid && (e.owner == OWN_I)) begin
            r.squash = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Tag pipeline for the port arbiter: a MEM_LAT-deep shift register that
// follows each granted read through the memory latency, applies flush
// squashing to fetch entries, and decodes the head into the two response
// channels when the memory data arrives.
module arb_tag_pipe
    import arb_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_en,
    input  logic              push_owner,
    input  logic              flush,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              squash_pop
);

    tag_entry_t stage_reg  [MEM_LAT];
    tag_entry_t stage_next [MEM_LAT];
    tag_entry_t push_entry;
    tag_entry_t head;

    assign push_entry.valid  = push_en;
    assign push_entry.owner  = push_owner;
    assign push_entry.squash = 1'b0;

    // The entry entering the pipe is squashed too if it is a fetch issued
    // in the flush cycle. The head being popped this cycle is not touched:
    // its data is already on mem_rdata and is delivered.
    assign stage_next[0] = age_entry(push_entry, flush);

    genvar gi;
    generate
        for (gi = 1; gi < MEM_LAT; gi++) begin : g_shift
            assign stage_next[gi] = age_entry(stage_reg[gi-1], flush);
        end
    endgenerate

    // Shift register; reset drops every in-flight entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MEM_LAT; i++) begin
                stage_reg[i] <= stage_next[i];
            end
        end
    end

    assign head = stage_reg[MEM_LAT-1];

    // Pop decode: route the returning word to its owner, zero elsewhere.
    always_comb begin
        if_rsp_valid = 1'b0;
        d_rsp_valid  = 1'b0;
        if_rsp_data  = '0;
        d_rsp_data   = '0;
        squash_pop   = 1'b0;
        if (head.valid) begin
            if (head.owner == OWN_D) begin
                d_rsp_valid = 1'b1;
                d_rsp_data  = mem_rdata;
            end else if (head.squash) begin
                squash_pop  = 1'b1;
            end else begin
                if_rsp_valid = 1'b1;
                if_rsp_data  = mem_rdata;
            end
        end
    end

endmodule

// File: rtl/imem_dmem_port_arbiter.sv
// Arbiter sharing one single-ported fixed-latency memory between
// instruction fetch and data load/store. Data wins by default; a bounded
// streak counter forces a fetch grant after MAX_D_STREAK data grants while
// fetch waits. Read responses are routed back via arb_tag_pipe, and flush
// squashes in-flight fetch reads.
// Optional: define ARB_PERF_CNT_EN to add saturating stall/squash counters.
module imem_dmem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,  // multiple of 8
    parameter int MEM_LAT      = 2,   // 1..4
    parameter int MAX_D_STREAK = 4    // 1..15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_we,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,
    input  logic                flush,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_if_stall,
    output logic [31:0]         perf_d_stall,
    output logic [31:0]         perf_squash
`endif
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_e          state_reg;
    arb_state_e          state_next;
    logic [STREAK_W-1:0] streak_reg;
    logic [STREAK_W-1:0] streak_next;
    logic                i_gnt;
    logic                d_gnt;
    logic                push_en;
    logic                push_owner;
    logic                squash_pop;

    // Grant selection, streak update and next state. Grants are forced off
    // while reset is asserted so nothing reaches the memory.
    always_comb begin
        i_gnt       = 1'b0;
        d_gnt       = 1'b0;
        state_next  = state_reg;
        streak_next = streak_reg;

        if (rst_n) begin
            if (state_reg == ARB_D) begin
                d_gnt = d_req_valid;
                i_gnt = if_req_valid && !d_req_valid;
            end else begin
                i_gnt = if_req_valid;
                d_gnt = d_req_valid && !if_req_valid;
            end
        end

        // Only data grants that keep fetch waiting count toward the streak.
        if (!if_req_valid || i_gnt) begin
            streak_next = '0;
        end else if (d_gnt && (streak_reg != STREAK_MAX)) begin
            streak_next = streak_reg + STREAK_W'(1);
        end

        case (state_reg)
            ARB_D: if (streak_next == STREAK_MAX) state_next = ARB_I;
            ARB_I: if (i_gnt || !if_req_valid)    state_next = ARB_D;
            default:                              state_next = ARB_D;
        endcase
    end

    // State and streak registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ARB_D;
            streak_reg <= '0;
        end else begin
            state_reg  <= state_next;
            streak_reg <= streak_next;
        end
    end

    // Memory port: the winner's request goes out in its grant cycle.
    always_comb begin
        if_req_ready = i_gnt;
        d_req_ready  = d_gnt;
        mem_en       = i_gnt || d_gnt;
        mem_we       = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (i_gnt) begin
            mem_addr  = if_addr;
        end
    end

    // Every read grant is tracked; stores push an empty slot.
    assign push_en    = i_gnt || (d_gnt && (d_we == '0));
    assign push_owner = d_gnt ? OWN_D : OWN_I;

    arb_tag_pipe #(
        .MEM_LAT (MEM_LAT),
        .DATA_W  (DATA_W)
    ) u_tag_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_en      (push_en),
        .push_owner   (push_owner),
        .flush        (flush),
        .mem_rdata    (mem_rdata),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .squash_pop   (squash_pop)
    );

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall_reg;
    logic [31:0] perf_d_stall_reg;
    logic [31:0] perf_squash_reg;

    // Saturating event counters for stalls and squashed fetch responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_if_stall_reg <= '0;
            perf_d_stall_reg  <= '0;
            perf_squash_reg   <= '0;
        end else begin
            if (if_req_valid && !i_gnt && (perf_if_stall_reg != '1))
                perf_if_stall_reg <= perf_if_stall_reg + 32'd1;
            if (d_req_valid && !d_gnt && (perf_d_stall_reg != '1))
                perf_d_stall_reg <= perf_d_stall_reg + 32'd1;
            if (squash_pop && (perf_squash_reg != '1))
                perf_squash_reg <= perf_squash_reg + 32'd1;
        end
    end

    assign perf_if_stall = perf_if_stall_reg;
    assign perf_d_stall  = perf_d_stall_reg;
    assign perf_squash   = perf_squash_reg;
`else
    logic unused_squash_pop;
    assign unused_squash_pop = squash_pop;
`endif

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Scoreboard bench for imem_dmem_port_arbiter (MEM_LAT=2, MAX_D_STREAK=4).
// Stimulus pushes hand-computed expected responses; a monitor pops and
// compares whenever a response is presented.
module tb_imem_dmem_port_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int MEM_LAT      = 2;
    localparam int MAX_D_STREAK = 4;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_I    = 2'd1;
    localparam logic [1:0] G_D    = 2'd2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req_valid = 1'b0;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;
    logic              d_req_valid = 1'b0;
    logic              d_req_ready;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [3:0]        d_we = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_data;
    logic              flush = 1'b0;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]       perf_if_stall;
    logic [31:0]       perf_d_stall;
    logic [31:0]       perf_squash;
`endif

    imem_dmem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MEM_LAT      (MEM_LAT),
        .MAX_D_STREAK (MAX_D_STREAK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_addr       (d_addr),
        .d_we         (d_we),
        .d_wdata      (d_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .flush        (flush),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_stall (perf_if_stall),
        .perf_d_stall  (perf_d_stall),
        .perf_squash   (perf_squash)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: word at index a starts as 0x1000_0000 + a; byte writes;
    // read data appears MEM_LAT cycles after the access cycle.
    logic [31:0] mem [256];
    logic [31:0] rd_pipe [MEM_LAT];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
            mem_init <= 1'b1;
        end else if (mem_en && (mem_we != 4'b0)) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        rd_pipe[0] <= mem[mem_addr[7:0]];
        for (int k = 1; k < MEM_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    int tests = 0;
    int fails = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] cyc;
    } exp_t;

    exp_t if_q[$];
    exp_t d_q[$];

    // One request cycle: drive inputs, check the grant and memory port,
    // and queue the expected response when a read is granted.
    task automatic issue(input logic iv, input logic [31:0] ia,
                         input logic dv, input logic [31:0] da,
                         input logic [3:0] dwe, input logic [31:0] dwd,
                         input logic fl, input logic [1:0] g,
                         input logic exp_rsp, input logic [31:0] rsp);
        exp_t e;
        @(negedge clk);
        if_req_valid = iv; if_addr = ia;
        d_req_valid = dv; d_addr = da; d_we = dwe; d_wdata = dwd;
        flush = fl;
        #2;
        check("if_req_ready", 32'(if_req_ready), 32'(g == G_I));
        check("d_req_ready",  32'(d_req_ready),  32'(g == G_D));
        check("mem_en",       32'(mem_en),       32'(g != G_NONE));
        check("mem_addr", mem_addr, (g == G_I) ? ia : (g == G_D) ? da : 32'h0);
        check("mem_we", 32'(mem_we), (g == G_D) ? 32'(dwe) : 32'h0);
        if (g == G_D) check("mem_wdata", mem_wdata, dwd);
        if (exp_rsp) begin
            e.data = rsp;
            e.cyc  = cyc + MEM_LAT;
            if (g == G_I) if_q.push_back(e);
            else          d_q.push_back(e);
        end
        if (g != G_NONE)
            $display("[TB] cyc %0d grant %s addr=%h we=%b flush=%0d", cyc,
                     (g == G_I) ? "I" : "D", mem_addr, mem_we, fl);
    endtask

    task automatic idle(input int n, input logic fl);
        for (int k = 0; k < n; k++) issue(1'b0, 0, 1'b0, 0, 4'b0, 0, fl, G_NONE, 1'b0, 0);
    endtask

    task automatic check_zero();
        check("rst_if_req_ready", 32'(if_req_ready), 0);
        check("rst_d_req_ready",  32'(d_req_ready), 0);
        check("rst_mem_en",       32'(mem_en), 0);
        check("rst_mem_we",       32'(mem_we), 0);
        check("rst_mem_addr",     mem_addr, 0);
        check("rst_mem_wdata",    mem_wdata, 0);
        check("rst_if_rsp_valid", 32'(if_rsp_valid), 0);
        check("rst_if_rsp_data",  if_rsp_data, 0);
        check("rst_d_rsp_valid",  32'(d_rsp_valid), 0);
        check("rst_d_rsp_data",   d_rsp_data, 0);
    endtask

    // Response monitor.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_rsp_valid) begin
                $display("[TB] cyc %0d if_rsp data=%h", cyc, if_rsp_data);
                if (if_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL if_rsp_unexpected: got data %h at cyc %0d, required no response", if_rsp_data, cyc);
                end else begin
                    e = if_q.pop_front();
                    check("if_rsp_data", if_rsp_data, e.data);
                    check("if_rsp_cycle", cyc, e.cyc);
                    check("d_rsp_data_while_if", d_rsp_data, 0);
                end
            end
            if (d_rsp_valid) begin
                $display("[TB] cyc %0d d_rsp data=%h", cyc, d_rsp_data);
                if (d_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL d_rsp_unexpected: got data %h at cyc %0d, required no response", d_rsp_data, cyc);
                end else begin
                    e = d_q.pop_front();
                    check("d_rsp_data", d_rsp_data, e.data);
                    check("d_rsp_cycle", cyc, e.cyc);
                    check("if_rsp_data_while_d", if_rsp_data, 0);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        string pat;
        logic [31:0] ia;
        logic [31:0] da;

        // Power-on reset with both requesters active: everything must stay 0.
        if_req_valid = 1'b1; if_addr = 32'h44;
        d_req_valid = 1'b1; d_addr = 32'h48; d_we = 4'hF; d_wdata = 32'h1234_5678;
        repeat (3) @(negedge clk);
        #2 check_zero();
        @(negedge clk);
        rst_n = 1'b1;
        if_req_valid = 1'b0; d_req_valid = 1'b0; d_we = 4'h0;

        // Reset in the cycle after a fetch grant: its response must never appear.
        idle(2, 1'b0);
        issue(1'b1, 32'h40, 1'b0, 0, 4'b0, 0, 1'b0, G_I, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        if_req_valid = 1'b1; if_addr = 32'h4C;
        d_req_valid = 1'b1; d_addr = 32'h50; d_we = 4'hF; d_wdata = 32'hCAFE_F00D;
        #2 check_zero();
        @(negedge clk);
        #2 check_zero();
        @(negedge clk);
        rst_n = 1'b1;
        if_req_valid = 1'b0; d_req_valid = 1'b0; d_we = 4'h0;
        idle(3, 1'b0);

        // Fetch stream 0x00..0x1C, back to back.
        for (int k = 0; k < 8; k++)
            issue(1'b1, 32'(4*k), 1'b0, 0, 4'b0, 0, 1'b0, G_I, 1'b1, 32'h1000_0000 + 32'(4*k));
        idle(3, 1'b0);

        // Both requesting: four data grants then one fetch, repeating.
        pat = "DDDDIDDDDI";
        ia = 32'h80;
        da = 32'hC0;
        for (int k = 0; k < 10; k++) begin
            if (pat[k] == "D") begin
                issue(1'b1, ia, 1'b1, da, 4'b0, 0, 1'b0, G_D, 1'b1, 32'h1000_0000 + da);
                da = da + 32'd4;
            end else begin
                issue(1'b1, ia, 1'b1, da, 4'b0, 0, 1'b0, G_I, 1'b1, 32'h1000_0000 + ia);
                ia = ia + 32'd4;
            end
        end
        idle(3, 1'b0);

        // Flush two cycles after fetching 0x10: only 0x10 returns.
        issue(1'b1, 32'h10, 1'b0, 0, 4'b0, 0, 1'b0, G_I, 1'b1, 32'h1000_0010);
        issue(1'b1, 32'h14, 1'b0, 0, 4'b0, 0, 1'b0, G_I, 1'b0, 0);
        issue(1'b1, 32'h18, 1'b0, 0, 4'b0, 0, 1'b1, G_I, 1'b0, 0);
        idle(4, 1'b0);
`ifdef ARB_PERF_CNT_EN
        check("perf_squash_after_flush", perf_squash, 32'd2);
`endif

        // Half-word store then load of the same word: no response for the store.
        issue(1'b0, 0, 1'b1, 32'h20, 4'b0011, 32'hDEAD_BEEF, 1'b0, G_D, 1'b0, 0);
        issue(1'b0, 0, 1'b1, 32'h20, 4'b0000, 0, 1'b0, G_D, 1'b1, 32'h1000_BEEF);
        idle(3, 1'b0);

        // Alternating data/fetch reads with flush held: data only.
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0)
                issue(1'b0, 0, 1'b1, 32'h30 + 32'(4*k), 4'b0, 0, 1'b1, G_D, 1'b1, 32'h1000_0030 + 32'(4*k));
            else
                issue(1'b1, 32'h30 + 32'(4*k), 1'b0, 0, 4'b0, 0, 1'b1, G_I, 1'b0, 0);
        end
        idle(4, 1'b1);
        idle(2, 1'b0);

`ifdef ARB_PERF_CNT_EN
        check("perf_squash_total", perf_squash, 32'd5);
        check("perf_if_stall", perf_if_stall, 32'd8);
        check("perf_d_stall", perf_d_stall, 32'd2);
`endif
        check("if_q_drained", 32'(if_q.size()), 0);
        check("d_q_drained", 32'(d_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
